w_feed: RTL and testbench

Write-side front end for the asynchronous RAM FIFO, in the write clock domain, directly upstream of the write-pointer controller. It accepts a valid/ready byte stream with frame markers and holds it in a 2-entry skid buffer. It drives the controller's write enable and RAM write data, and never asserts a write while the FIFO reports full, so no word is ever silently dropped. It also keeps word, frame and stall statistics for debug readback.

---
 rtl/fifo_pkg.sv | 18 +
 rtl/w_feed_if.sv | 29 ++
 rtl/w_feed_sat_cnt.sv | 25 ++
 rtl/w_feed.sv | 113 +++++++++++
 tb/tb_w_feed.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the asynchronous RAM FIFO write/read controllers.
//   state_t    : write-front-end skid buffer occupancy states
//   DATA_W_DEF : default stream / RAM data width
//   CNT_W_DEF  : default statistics counter width
//   PTR_W      : FIFO pointer width shared by write and read controllers
package fifo_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    localparam int DATA_W_DEF = 8;
    localparam int CNT_W_DEF  = 16;
    localparam int PTR_W      = 5;

endpackage

// File: rtl/w_feed_if.sv
// Bundle of the upstream valid/ready stream and the write-port side of the
// write-pointer controller, as seen by the w_feed block.
//   s_valid/s_data/s_last/s_ready : upstream byte stream with frame marker
//   w_full                        : FIFO full flag from the controller
//   w_en/w_data/w_last            : write enable and RAM write data
// slave  : view of w_feed itself
// master : view of the surrounding environment (upstream + controller)
interface w_feed_if #(
    parameter int DATA_W = fifo_pkg::DATA_W_DEF
);
    logic              s_valid;
    logic [DATA_W-1:0] s_data;
    logic              s_last;
    logic              s_ready;
    logic              w_full;
    logic              w_en;
    logic [DATA_W-1:0] w_data;
    logic              w_last;

    modport slave (
        input  s_valid, s_data, s_last, w_full,
        output s_ready, w_en, w_data, w_last
    );

    modport master (
        output s_valid, s_data, s_last, w_full,
        input  s_ready, w_en, w_data, w_last
    );
endinterface

// File: rtl/w_feed_sat_cnt.sv
// Saturating up-counter used for debug statistics.
//   w_clk : clock, rising edge
//   rst   : asynchronous active-high reset (clears count)
//   clr   : synchronous clear
//   inc   : increment request; ignored once the count is all-ones
//   cnt   : current count
module sat_cnt #(
    parameter int CNT_W = fifo_pkg::CNT_W_DEF
) (
    input  logic             w_clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);
    always_ff @(posedge w_clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/w_feed.sv
// Write-side front end of the asynchronous RAM FIFO (write clock domain).
// Holds the upstream stream in a 2-entry skid buffer and issues RAM writes
// only while the controller reports not-full, so no word is dropped.
//   w_clk     : write-domain clock
//   rst       : asynchronous active-high reset
//   bus       : stream in (s_*), write port out (w_en/w_data/w_last), w_full in
//   word_cnt  : words written, saturating
//   frame_cnt : words written with last=1, wrapping
//   stall_cnt : cycles with data pending while full, saturating
module w_feed
    import fifo_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic             w_clk,
    input  logic             rst,
    w_feed_if.slave          bus,
    output logic [CNT_W-1:0] word_cnt,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [CNT_W-1:0] stall_cnt
);
    state_t            state, nxt;
    logic [DATA_W:0]   ent0_q, ent1_q;   // {last, data}; ent0 is the head
    logic              s_ready_q;
    logic              acc, drn;
    logic              ld0, ld1, mv;

    assign acc = bus.s_valid & s_ready_q;
    // Combinational so a same-cycle w_full can block the write.
    assign drn = (state != EMPTY) & ~bus.w_full;

    assign bus.w_en    = drn;
    assign bus.s_ready = s_ready_q;
    assign bus.w_data  = ent0_q[DATA_W-1:0];
    assign bus.w_last  = ent0_q[DATA_W];

    always_comb begin
        nxt = state;
        ld0 = 1'b0;
        ld1 = 1'b0;
        mv  = 1'b0;
        case (state)
            EMPTY: begin
                if (acc) begin
                    nxt = ONE;
                    ld0 = 1'b1;
                end
            end
            ONE: begin
                if (acc && drn) begin
                    ld0 = 1'b1;          // head leaves, new word takes its place
                end else if (acc) begin
                    nxt = TWO;
                    ld1 = 1'b1;
                end else if (drn) begin
                    nxt = EMPTY;
                end
            end
            TWO: begin
                if (drn) begin
                    nxt = ONE;
                    mv  = 1'b1;
                end
            end
            default: nxt = EMPTY;
        endcase
    end

    always_ff @(posedge w_clk or posedge rst) begin
        if (rst) begin
            state     <= EMPTY;
            s_ready_q <= 1'b0;
            ent0_q    <= '0;
            ent1_q    <= '0;
        end else begin
            state     <= nxt;
            s_ready_q <= (nxt != TWO);
            if (ld0) begin
                ent0_q <= {bus.s_last, bus.s_data};
            end else if (mv) begin
                ent0_q <= ent1_q;
            end
            if (ld1) begin
                ent1_q <= {bus.s_last, bus.s_data};
            end
        end
    end

    sat_cnt #(.CNT_W(CNT_W)) u_word_cnt (
        .w_clk (w_clk),
        .rst   (rst),
        .clr   (1'b0),
        .inc   (drn),
        .cnt   (word_cnt)
    );

    sat_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
        .w_clk (w_clk),
        .rst   (rst),
        .clr   (1'b0),
        .inc   ((state != EMPTY) & bus.w_full),
        .cnt   (stall_cnt)
    );

    always_ff @(posedge w_clk or posedge rst) begin
        if (rst) begin
            frame_cnt <= '0;
        end else if (drn && ent0_q[DATA_W]) begin
            frame_cnt <= frame_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_w_feed.sv
// Self-checking bench for w_feed: a queue model of the pending words is
// compared with the DUT on every falling edge, plus literal checks per test.
module tb_w_feed;
    logic        w_clk = 1'b0;
    logic        rst   = 1'b1;
    logic [15:0] word_cnt, frame_cnt, stall_cnt;
    logic [3:0]  word_cnt_b, frame_cnt_b, stall_cnt_b;

    int n_cmp = 0;
    int n_bad = 0;

    w_feed_if #(.DATA_W(8)) bus ();
    w_feed_if #(.DATA_W(8)) busb ();

    w_feed #(.DATA_W(8), .CNT_W(16)) dut (
        .w_clk     (w_clk),
        .rst       (rst),
        .bus       (bus.slave),
        .word_cnt  (word_cnt),
        .frame_cnt (frame_cnt),
        .stall_cnt (stall_cnt)
    );

    w_feed #(.DATA_W(8), .CNT_W(4)) dut_b (
        .w_clk     (w_clk),
        .rst       (rst),
        .bus       (busb.slave),
        .word_cnt  (word_cnt_b),
        .frame_cnt (frame_cnt_b),
        .stall_cnt (stall_cnt_b)
    );

    always #5 w_clk = ~w_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [8:0] mq[$];        // pending {last,data} in acceptance order
    bit         m_ready = 1'b0;
    int         m_words = 0, m_frames = 0, m_stall = 0;
    bit         out_last[$];  // w_last of every written word

    always @(negedge w_clk) begin
        bit         exp_wen;
        logic [8:0] h;
        if (rst) begin
            chk("rst_s_ready", bus.s_ready, 0);
            chk("rst_w_en", bus.w_en, 0);
            chk("rst_w_data", bus.w_data, 0);
            chk("rst_w_last", bus.w_last, 0);
            chk("rst_word_cnt", word_cnt, 0);
            chk("rst_frame_cnt", frame_cnt, 0);
            chk("rst_stall_cnt", stall_cnt, 0);
            mq.delete();
            m_ready = 1'b0;
            m_words = 0; m_frames = 0; m_stall = 0;
        end else begin
            exp_wen = (mq.size() > 0) && !bus.w_full;
            chk("w_en", bus.w_en, exp_wen);
            chk("s_ready", bus.s_ready, m_ready);
            if (exp_wen) begin
                chk("w_data", bus.w_data, mq[0][7:0]);
                chk("w_last", bus.w_last, mq[0][8]);
            end
            chk("word_cnt", word_cnt, m_words);
            chk("frame_cnt", frame_cnt, m_frames);
            chk("stall_cnt", stall_cnt, m_stall);
            // advance to the next rising edge
            if (mq.size() > 0 && bus.w_full && m_stall < 65535) m_stall++;
            if (exp_wen) begin
                h = mq.pop_front();
                if (m_words < 65535) m_words++;
                if (h[8]) m_frames = (m_frames + 1) % 65536;
                out_last.push_back(bus.w_last);
            end
            if (bus.s_valid && m_ready) mq.push_back({bus.s_last, bus.s_data});
            m_ready = (mq.size() < 2);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input logic [7:0] d, input bit l);
        bit ok = 1'b0;
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        bus.s_last  = l;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge w_clk);
            if (bus.s_ready) begin
                @(posedge w_clk);
                #1;
                ok = 1'b1;
            end
        end
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout: word %0h not accepted, expected accept", d);
        end
    endtask

    task automatic idle(input int n);
        bus.s_valid = 1'b0;
        repeat (n) begin
            @(posedge w_clk);
            #1;
        end
    endtask

    task automatic do_reset();
        @(posedge w_clk);
        #1;
        rst = 1'b1;
        bus.s_valid = 1'b0;
        bus.w_full  = 1'b0;
        repeat (2) @(posedge w_clk);
        #1;
        rst = 1'b0;
        @(posedge w_clk);
        #1;
        chk("ready_after_rst", bus.s_ready, 1);
        out_last.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1);
    end

    initial begin
        bit tog_done;
        bus.s_valid = 1'b0; bus.s_data = '0; bus.s_last = 1'b0; bus.w_full = 1'b0;
        busb.s_valid = 1'b0; busb.s_data = '0; busb.s_last = 1'b0; busb.w_full = 1'b0;
        #1;
        chk("init_s_ready", bus.s_ready, 0);
        chk("init_w_en", bus.w_en, 0);
        do_reset();

        // Test 1: four words back to back, no backpressure
        send(8'h11, 1'b0);
        chk("t1_first_wen", bus.w_en, 1);
        chk("t1_first_data", bus.w_data, 8'h11);
        send(8'h22, 1'b0);
        send(8'h33, 1'b0);
        send(8'h44, 1'b0);
        idle(4);
        chk("t1_word_cnt", word_cnt, 4);
        chk("t1_stall_cnt", stall_cnt, 0);

        // Test 2: full held while upstream keeps offering words
        do_reset();
        bus.w_full = 1'b1;
        send(8'hA1, 1'b0);
        send(8'hA2, 1'b0);
        bus.s_data = 8'hA3;              // held, not accepted yet
        repeat (4) begin
            @(posedge w_clk);
            #1;
        end
        chk("t2_s_ready", bus.s_ready, 0);
        chk("t2_w_en", bus.w_en, 0);
        chk("t2_stall_cnt", stall_cnt, 5);
        chk("t2_word_cnt", word_cnt, 0);
        bus.w_full = 1'b0;
        #1;
        chk("t2_wen_same_cycle", bus.w_en, 1);
        chk("t2_head", bus.w_data, 8'hA1);
        send(8'hA3, 1'b0);
        idle(4);
        chk("t2_word_cnt_end", word_cnt, 3);

        // Test 3: w_full toggling every cycle, 20 words
        do_reset();
        tog_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 20; i++) send(8'(8'h60 + i), 1'b0);
                bus.s_valid = 1'b0;
                tog_done = 1'b1;
            end
            begin
                while (!tog_done) begin
                    @(posedge w_clk);
                    #1;
                    if (!tog_done) bus.w_full = ~bus.w_full;
                end
            end
        join
        bus.w_full = 1'b0;
        idle(5);
        chk("t3_word_cnt", word_cnt, 20);

        // Test 4: frames of length 1, 3, 2
        do_reset();
        send(8'h01, 1'b1);
        send(8'h02, 1'b0);
        send(8'h03, 1'b0);
        send(8'h04, 1'b1);
        send(8'h05, 1'b0);
        send(8'h06, 1'b1);
        idle(4);
        chk("t4_frame_cnt", frame_cnt, 3);
        chk("t4_nwords", out_last.size(), 6);
        if (out_last.size() == 6) begin
            chk("t4_last_pattern",
                {26'd0, out_last[0], out_last[1], out_last[2], out_last[3], out_last[4], out_last[5]},
                32'b100101);
        end

        // Test 5: reset while two words are pending
        do_reset();
        send(8'h51, 1'b1);
        send(8'h52, 1'b0);
        idle(2);
        bus.w_full = 1'b1;
        send(8'h53, 1'b0);
        send(8'h54, 1'b1);
        bus.s_valid = 1'b0;
        chk("t5_pre_ready", bus.s_ready, 0);
        chk("t5_pre_word_cnt", word_cnt, 2);
        chk("t5_pre_frame_cnt", frame_cnt, 1);
        chk("t5_pre_stall_cnt", stall_cnt, 1);
        #2;
        rst = 1'b1;
        bus.w_full = 1'b0;
        #1;
        chk("t5_rst_w_en", bus.w_en, 0);
        chk("t5_rst_s_ready", bus.s_ready, 0);
        chk("t5_rst_word_cnt", word_cnt, 0);
        chk("t5_rst_frame_cnt", frame_cnt, 0);
        chk("t5_rst_stall_cnt", stall_cnt, 0);
        @(posedge w_clk);
        #1;
        rst = 1'b0;
        @(posedge w_clk);
        #1;
        chk("t5_ready_first_edge", bus.s_ready, 1);
        idle(4);
        chk("t5_no_stale_word", word_cnt, 0);

        // Test 6: 4-bit counters, 17 one-word frames
        do_reset();
        busb.s_last = 1'b1;
        for (int i = 0; i < 17; i++) begin
            busb.s_valid = 1'b1;
            busb.s_data  = 8'(i);
            @(negedge w_clk);
            chk("t6_ready", busb.s_ready, 1);
            @(posedge w_clk);
            #1;
        end
        busb.s_valid = 1'b0;
        repeat (4) begin
            @(posedge w_clk);
            #1;
        end
        chk("t6_word_cnt_sat", word_cnt_b, 15);
        chk("t6_frame_cnt_wrap", frame_cnt_b, 1);
        chk("t6_stall_cnt", stall_cnt_b, 0);
        repeat (2) @(posedge w_clk);
        #1;
        chk("t6_word_cnt_hold", word_cnt_b, 15);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
